axi_burst_master: RTL

Command-driven AXI4 master that issues single-outstanding INCR write or read bursts into the downstream AXI4 RAM slave. Write payload comes from an AXI-Stream-style input; read payload goes to an AXI-Stream-style output. A one-cycle `done` pulse with the response code reports each command's completion. It sits directly upstream of the RAM slave and connects port-for-port to its `s_axi_*` interface.

---
 rtl/axi_burst_master_if.sv | 74 +++++++
 rtl/axi_burst_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master_if.sv
// AXI4 master/slave channel bundle connecting the burst master to the RAM slave.
interface axi_burst_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Command-driven AXI4 master: one outstanding INCR write or read burst at a time,
// write data streamed in, read data streamed out, done pulse with response code.
module axi_burst_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] s_wr_tdata,
  input  logic                  s_wr_tvalid,
  output logic                  s_wr_tready,
  output logic [DATA_WIDTH-1:0] m_rd_tdata,
  output logic                  m_rd_tlast,
  output logic                  m_rd_tvalid,
  input  logic                  m_rd_tready,
  output logic                  done,
  output logic [1:0]            done_resp,
  axi_burst_master_if.master    m_axi
);
  localparam int unsigned SIZE_LOG2  = $clog2(STRB_WIDTH);
  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_aligned;
  logic [7:0]            len_q, len_d, cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]            sticky_q, sticky_d, resp_d;
  logic                  done_d;
  logic                  awvalid_q, arvalid_q, bready_q;
  logic [31:0]           span;
  logic                  crosses_4k, w_hs, r_hs;
  logic                  unused_ids;

  // Start address rounded down to a full bus word; the page check uses the bytes actually touched.
  assign addr_aligned = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign span         = 32'(addr_aligned[11:0]) + (32'(cmd_len) + 32'd1) * STRB_WIDTH;
  assign crosses_4k   = span > PAGE_BYTES;

  assign w_hs = (state_q == W) && s_wr_tvalid && m_axi.wready;
  assign r_hs = (state_q == R) && m_axi.rvalid && m_rd_tready;

  // Response IDs are not checked: only one burst is ever outstanding.
  assign unused_ids = ^{m_axi.bid, m_axi.rid};

  // State, latched command and registered handshake/completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      sticky_q  <= '0;
      cmd_ready <= 1'b0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done      <= 1'b0;
      done_resp <= 2'b00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      sticky_q  <= sticky_d;
      cmd_ready <= (state_d == IDLE);
      awvalid_q <= (state_d == AW);
      arvalid_q <= (state_d == AR);
      bready_q  <= (state_d == B);
      done      <= done_d;
      done_resp <= resp_d;
    end
  end

  // Next-state, beat counting and completion response.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    resp_d   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (crosses_4k) begin
            done_d = 1'b1;
            resp_d = 2'b10;
          end else begin
            addr_d   = addr_aligned;
            len_d    = cmd_len;
            cnt_d    = cmd_len;
            id_d     = cmd_id;
            sticky_d = 2'b00;
            state_d  = cmd_write ? AW : AR;
          end
        end
      end
      AW: if (m_axi.awready) state_d = W;
      W: begin
        if (w_hs) begin
          if (cnt_q == 8'd0) state_d = B;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      B: begin
        if (m_axi.bvalid) begin
          done_d  = 1'b1;
          resp_d  = m_axi.bresp;
          state_d = IDLE;
        end
      end
      AR: if (m_axi.arready) state_d = R;
      R: begin
        if (r_hs) begin
          if (sticky_q == 2'b00) sticky_d = m_axi.rresp;
          if (cnt_q != 8'd0)     cnt_d    = cnt_q - 8'd1;
          if (m_axi.rlast) begin
            done_d  = 1'b1;
            resp_d  = (cnt_q != 8'd0) ? 2'b10 : sticky_d;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address channels: fields come from the latched command and stay stable while valid.
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = 3'(SIZE_LOG2);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awid    = id_q;

  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = 3'(SIZE_LOG2);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arid    = id_q;

  assign m_axi.bready  = bready_q;

  // Data pass-through, gated off outside its own state.
  assign m_axi.wvalid = (state_q == W) && s_wr_tvalid;
  assign s_wr_tready  = (state_q == W) && m_axi.wready;
  assign m_axi.wdata  = (state_q == W) ? s_wr_tdata : '0;
  assign m_axi.wstrb  = (state_q == W) ? '1 : '0;
  assign m_axi.wlast  = (state_q == W) && (cnt_q == 8'd0);

  assign m_rd_tvalid  = (state_q == R) && m_axi.rvalid;
  assign m_axi.rready = (state_q == R) && m_rd_tready;
  assign m_rd_tdata   = (state_q == R) ? m_axi.rdata : '0;
  assign m_rd_tlast   = (state_q == R) && m_axi.rlast;
endmodule
